// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA timing generator.
//   - 640x480@60 mode constants (default parameter set of vga_timing_gen)
//   - 3:3:2 colour field widths and bit slices for an 8-bit pixel
//   - sync_t: one stage of the sync/enable delay line
//   - seg_active(): membership test for a counter segment [start, start+len)
package vga_pkg;

  // 640x480@60, 25 MHz pixel clock derived from 50 MHz
  localparam int VGA_PXL_DIV  = 2;
  localparam int VGA_H_DISP   = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC_W = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_DISP   = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC_W = 2;
  localparam int VGA_V_BP     = 29;
  localparam int VGA_CNT_W    = 11;
  localparam int VGA_COLOR_W  = 8;

  // 3:3:2 packing: R[7:5], G[4:2], B[1:0]
  localparam int COLOR_R_W  = 3;
  localparam int COLOR_G_W  = 3;
  localparam int COLOR_B_W  = 2;
  localparam int COLOR_R_HI = 7;
  localparam int COLOR_R_LO = 5;
  localparam int COLOR_G_HI = 4;
  localparam int COLOR_G_LO = 2;
  localparam int COLOR_B_HI = 1;
  localparam int COLOR_B_LO = 0;

  // Active-true sync/enable flags; polarity is applied only at the outputs.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Callers guarantee start+len fits the counter width, so 32-bit
  // evaluation gives the same result as counter-width arithmetic.
  function automatic logic seg_active(input logic [31:0] cnt,
                                      input logic [31:0] start,
                                      input logic [31:0] len);
    return (cnt >= start) && (cnt < start + len);
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// vga_pixel_div: pixel-rate enable generator.
//   clk_i    - system clock
//   rst_i    - synchronous active-high reset
//   pxl_en_o - one-cycle tick every PXL_DIV cycles (held high when PXL_DIV=1)
// The counter runs 0..PXL_DIV-1 and the tick is the cycle at PXL_DIV-1, so
// the first tick arrives PXL_DIV cycles after reset is released.
module vga_pixel_div #(
  parameter int PXL_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pxl_en_o
);

  localparam int DIV_W = (PXL_DIV > 1) ? $clog2(PXL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PXL_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = (cnt_q == DIV_LAST) ? '0 : cnt_q + DIV_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Tick is forced low while reset is asserted, including at PXL_DIV=1.
  assign pxl_en_o = ~rst_i & (cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator and pixel-output stage.
// Issues pixel coordinates RGB_LAT ticks ahead of the data, then realigns
// syncs and display enable with the RGB returned by the image source.
//   CLK_IN      - system clock
//   RST         - synchronous active-high reset
//   RGB_in      - pixel data, valid RGB_LAT ticks after its coordinate
//   TP_SEL      - (VGA_TEST_PATTERN_EN only) 1 = colour bars instead of RGB_in
//   xCoord/yCoord - requested pixel, 0 outside the active area (combinational)
//   REQ         - coordinate valid (combinational)
//   PXL_EN      - pixel tick (combinational)
//   FRAME_START - tick at H=0,V=0 (combinational)
//   H_SYNC/V_SYNC/DE/RGB - registered outputs, RGB_LAT ticks behind REQ
// Optional build macro: VGA_TEST_PATTERN_EN adds the TP_SEL port and an
// eight-bar colour test pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   PXL_DIV  = VGA_PXL_DIV,
  parameter int   H_DISP   = VGA_H_DISP,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC_W = VGA_H_SYNC_W,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_DISP   = VGA_V_DISP,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC_W = VGA_V_SYNC_W,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CNT_W    = VGA_CNT_W,
  parameter int   COLOR_W  = VGA_COLOR_W,
  parameter int   RGB_LAT  = 1
) (
  input  logic               CLK_IN,
  input  logic               RST,
  input  logic [COLOR_W-1:0] RGB_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               TP_SEL,
`endif
  output logic [CNT_W-1:0]   xCoord,
  output logic [CNT_W-1:0]   yCoord,
  output logic               REQ,
  output logic               PXL_EN,
  output logic               FRAME_START,
  output logic               H_SYNC,
  output logic               V_SYNC,
  output logic               DE,
  output logic [COLOR_W-1:0] RGB
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC_W + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC_W + V_BP;
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_DISP_C = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] V_DISP_C = CNT_W'(V_DISP);

  logic pxl_en;

  vga_pixel_div #(.PXL_DIV(PXL_DIV)) u_div (
    .clk_i    (CLK_IN),
    .rst_i    (RST),
    .pxl_en_o (pxl_en)
  );

  // ---------------------------------------------------------------- counters
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pxl_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // ----------------------------------------------------------------- stage 0
  logic  act0;
  sync_t stg0;

  assign act0     = (h_q < H_DISP_C) && (v_q < V_DISP_C);
  assign stg0.hs  = seg_active(32'(h_q), 32'(H_DISP + H_FP), 32'(H_SYNC_W));
  assign stg0.vs  = seg_active(32'(v_q), 32'(V_DISP + V_FP), 32'(V_SYNC_W));
  assign stg0.de  = act0;

  assign REQ         = act0;
  assign xCoord      = act0 ? h_q : '0;
  assign yCoord      = act0 ? v_q : '0;
  assign PXL_EN      = pxl_en;
  assign FRAME_START = pxl_en & (h_q == '0) & (v_q == '0);

  // -------------------------------------------------------------- delay line
  // Stage i holds the flags of the coordinate issued i ticks ago; the output
  // register then takes stage RGB_LAT together with the matching RGB_in.
  sync_t [RGB_LAT:1] pipe_q;

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      pipe_q <= '0;
    end else if (pxl_en) begin
      pipe_q[1] <= stg0;
      for (int i = 2; i <= RGB_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // ------------------------------------------------------------ pixel source
  logic [COLOR_W-1:0] rgb_src;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_DISP / 8;

  // x travels with the flags so the bars line up with DE.
  logic [RGB_LAT:1][CNT_W-1:0] xd_q;
  logic [CNT_W-1:0]            bar;

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      xd_q <= '0;
    end else if (pxl_en) begin
      xd_q[1] <= xCoord;
      for (int i = 2; i <= RGB_LAT; i++) xd_q[i] <= xd_q[i-1];
    end
  end

  assign bar     = xd_q[RGB_LAT] / CNT_W'(BAR_W);
  assign rgb_src = TP_SEL ? COLOR_W'({{COLOR_R_W{bar[2]}},
                                      {COLOR_G_W{bar[1]}},
                                      {COLOR_B_W{bar[0]}}})
                          : RGB_in;
`else
  assign rgb_src = RGB_in;
`endif

  // ------------------------------------------------------------ output stage
  // Polarity is applied here only, so reset drives the inactive level
  // directly and a truncated sync pulse cannot glitch active.
  logic               hs_q, vs_q, de_q;
  logic [COLOR_W-1:0] rgb_q;

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else if (pxl_en) begin
      hs_q  <= pipe_q[RGB_LAT].hs ? H_POL : ~H_POL;
      vs_q  <= pipe_q[RGB_LAT].vs ? V_POL : ~V_POL;
      de_q  <= pipe_q[RGB_LAT].de;
      rgb_q <= pipe_q[RGB_LAT].de ? rgb_src : '0;
    end
  end

  assign H_SYNC = hs_q;
  assign V_SYNC = vs_q;
  assign DE     = de_q;
  assign RGB    = rgb_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel-output stage. It is the successor to the fixed 640x480 driver. It derives a pixel-rate enable from the system clock and produces sync and data-enable signals for any mode given by parameters, with selectable sync polarity. It issues pixel coordinates ahead of the data and realigns syncs with RGB data returned by an upstream image source of fixed latency. It sits between the image/frame-buffer logic and the VGA DAC pins.

## Interface
- PXL_DIV, 2: CLK_IN cycles per pixel (1..16); 2 gives 25 MHz from 50 MHz.
- H_DISP, 640 / H_FP, 16 / H_SYNC_W, 96 / H_BP, 48: horizontal segment lengths in pixels.
- V_DISP, 480 / V_FP, 10 / V_SYNC_W, 2 / V_BP, 29: vertical segment lengths in lines.
- H_POL, 0 / V_POL, 0: active sync level (0 = active-low).
- CNT_W, 11: counter and coordinate width; must hold H_DISP+H_FP+H_SYNC_W+H_BP-1.
- COLOR_W, 8: RGB width (3:3:2 packing at 8).
- RGB_LAT, 1: pixel ticks from a coordinate to its RGB_in (1..4).

Ports:
- CLK_IN  in  1  system clock
- RST  in  1  synchronous, active-high reset
- RGB_in  in  COLOR_W  pixel data, sampled RGB_LAT ticks after its coordinate
- xCoord  out  CNT_W  requested column, 0 outside active area
- yCoord  out  CNT_W  requested row, 0 outside active area
- REQ  out  1  xCoord/yCoord valid (active area, undelayed)
- PXL_EN  out  1  one-cycle pixel tick
- FRAME_START  out  1  one-cycle pulse at tick where H=0,V=0 (undelayed)
- H_SYNC, V_SYNC  out  1  syncs, delayed RGB_LAT ticks
- DE  out  1  display enable, delayed RGB_LAT ticks
- RGB  out  COLOR_W  pixel output, 0 when DE low

## Operation
- Divider: counts 0..PXL_DIV-1; PXL_EN=1 in the cycle the count equals PXL_DIV-1. At PXL_DIV=1, PXL_EN is held 1.
- Horizontal and vertical counts (H, V) advance only on PXL_EN.
  - H wraps at H_TOT-1, where H_TOT = H_DISP+H_FP+H_SYNC_W+H_BP.
  - V increments only at an H wrap and wraps at V_TOT-1, defined the same way.
- Segment order: display, front porch, sync, back porch.
  - Active area: H<H_DISP and V<V_DISP.
  - Sync active: H_DISP+H_FP <= H < H_DISP+H_FP+H_SYNC_W; V uses the same rule with V parameters.
- Stage 0 is combinational from H and V: REQ, xCoord=H, yCoord=V. FRAME_START = PXL_EN & H==0 & V==0.
- Delay line: {hsync, vsync, de} is shifted RGB_LAT stages, advancing on PXL_EN only.
- Output register: on PXL_EN, RGB <= delayed DE ? RGB_in : 0. H_SYNC, V_SYNC and DE are registered from the last delay stage, with polarity applied at the output register.
- All outputs are registered except PXL_EN, FRAME_START, REQ, xCoord and yCoord.
- Comparisons use CNT_W-bit unsigned arithmetic. No parameter combination may cause a sum to overflow CNT_W.

## Timing
- Reset, applied in any cycle:
  - Divider, H and V return to 0 on the next edge; delay line flushes to inactive.
  - H_SYNC = ~H_POL, V_SYNC = ~V_POL, DE=0, RGB=0, PXL_EN=0, FRAME_START=0.
- First PXL_EN comes PXL_DIV cycles after reset deasserts, and H=V=0 at that tick.
- Latency:
  - The coordinate issued at tick t appears on RGB/DE at the CLK_IN edge ending tick t+RGB_LAT.
  - Syncs carry the same latency, so sync-to-data alignment is exact.
- Between ticks, all registered outputs hold their values.
- Simultaneous H wrap and V wrap at frame end: both counters go to 0 in the same tick, and FRAME_START fires at that tick.
- A reset during a sync pulse truncates the pulse; no glitch to the active level occurs.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds input TP_SEL (1 bit).
  - When TP_SEL=1, RGB_in is ignored. RGB shows eight vertical colour bars of width H_DISP/8, with bar k = {k[2] repeated, k[1] repeated, k[0] repeated} across the R, G and B fields.
  - The pattern is generated from the delayed x so it aligns with DE.
- Undefined: no TP_SEL port and no pattern logic; RGB always sources RGB_in.

## Structure
- Package vga_pkg holds:
  - mode parameter set for 640x480@60 as constants;
  - colour field widths and slices (R[7:5], G[4:2], B[1:0]);
  - function seg_active(cnt, start, len).
- One sub-module, vga_pixel_div, contains the divider and produces PXL_EN. H/V counters, the delay line and the output stage stay in vga_timing_gen.

## Test plan
- Defaults, reset released: PXL_EN period is 2 cycles; H_SYNC low for exactly 96 ticks, starting at H=656; V_SYNC low for lines 490-491; line = 800 ticks; frame = 521 lines.
- RGB_in driven as xCoord[7:0] with RGB_LAT=1: at DE rise RGB=0x00, at DE fall-1 RGB=0x7F (639 mod 256); RGB=0 during blanking.
- RGB_LAT=3: DE rises 3 ticks after REQ rises; H_SYNC edges shift equally.
- H_POL=1, V_POL=1: syncs high only during the sync segments; both are 0 during reset.
- Reset asserted mid-frame at H=700, V=300: one edge later H=V=0, RGB=0, DE=0; next FRAME_START comes 2 cycles after release.
- With VGA_TEST_PATTERN_EN and TP_SEL=1: RGB=0x00 for x 0-79, 0x03 for x 80-159, ..., 0xFF for x 560-639.
